adc_scan: RTL and testbench
===========================

ADC_SCAN -- requirements
Module: adc_scan

Interface
REQ-001 SHALL have parameter N_CHAN, default 2: number of ADC input channels, a power of two in 2..8; CH_W = log2(N_CHAN).
REQ-002 SHALL have parameter RES_BITS, default 10: conversion width, 10 or 12.
REQ-003 SHALL have parameter HALF_DIV, default 4: clk cycles per sck half-period, minimum 2.
REQ-004 SHALL have parameter CS_IDLE, default 2: minimum ncs-high time between frames, in sck half-periods, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-006 SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-shot request, rising edge detected internally.
REQ-008 SHALL have port chan, input, CH_W bits: single-shot channel select.
REQ-009 SHALL have port diff, input, 1 bit: 1 = pseudo-differential, 0 = single-ended.
REQ-010 SHALL have port scan_en, input, 1 bit: continuous round-robin scan enable.
REQ-011 SHALL have port scan_mask, input, N_CHAN bits: channels included in the scan.
REQ-012 SHALL have port miso, input, 1 bit: serial data from the ADC.
REQ-013 SHALL have port mosi, output, 1 bit: serial data to the ADC.
REQ-014 SHALL have port sck, output, 1 bit: SPI clock, idles low.
REQ-015 SHALL have port ncs, output, 1 bit: active-low chip select.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port data, output, RES_BITS bits: last completed conversion.
REQ-018 SHALL have port data_chan, output, CH_W bits: channel of data.
REQ-019 SHALL have port data_valid, output, 1 bit: one-clk pulse per completed frame.
REQ-020 SHALL have port overrun, output, 1 bit: sticky; set when a start edge arrives while busy.

Function
REQ-021 SHALL use SPI mode 0: mosi changes only while sck is low; miso is sampled on clk cycles where sck rises.
REQ-022 SHALL send each frame as FRAME = 4+CH_W+RES_BITS sck periods, in order:
- start bit = 1
- SGL/DIFF = ~diff
- channel, MSB first
- MSBF = 1
- one null bit (miso ignored)
- RES_BITS data bits, MSB first
REQ-023 SHALL hold mosi at 1 after the MSBF bit.
REQ-024 SHALL implement the state machine:
- IDLE -> CS_SETUP: on a start edge or a pending scan; ncs falls here.
- CS_SETUP -> SHIFT: after one half-period.
- SHIFT -> CS_HOLD: after the falling edge of sck period FRAME; ncs rises here.
- CS_HOLD -> IDLE: after CS_IDLE half-periods.
REQ-025 SHALL latch chan and diff on entry to CS_SETUP; changes during a frame SHALL NOT affect it.
REQ-026 SHALL update data and data_chan in the clk cycle after the last data bit is sampled, with data_valid high in that same cycle only.
REQ-027 SHALL give a start edge in IDLE priority over scan.
REQ-028 SHALL, with scan_en=1, convert the next set bit of scan_mask above the last scanned channel, wrapping from N_CHAN-1 to 0.
REQ-029 SHALL, with scan_mask all zero, treat scan as idle.
REQ-030 SHALL ignore a start edge while busy and set overrun; overrun SHALL clear only on reset.
REQ-031 SHALL let a deasserted scan_en stop further frames but SHALL complete the current frame.

Reset
REQ-032 SHALL, while nreset=0, force immediately: state IDLE, sck=0, ncs=1, mosi=0, busy=0, data=0, data_chan=0, data_valid=0, overrun=0, scan pointer=N_CHAN-1, start edge detector cleared.
REQ-033 SHALL abort any frame without a data_valid pulse on reset mid-frame.

Structure
REQ-034 SHALL place the state enum and the frame-field offset constants in package adc_pkg.
REQ-035 SHALL implement the sck half-period tick generator as sub-module clk_div, parametrised by HALF_DIV.

Verification
REQ-036 Default params, diff=0, chan=1, start pulse, ADC model returns 10'h2A5 -> mosi frame 1,1,1,1 then 1s; 15 sck periods; data=10'h2A5, data_chan=1, one data_valid pulse.
REQ-037 N_CHAN=8, RES_BITS=12, chan=5, diff=1 -> mosi bits 1,0,1,0,1,1; 19 sck periods; 12-bit data correct.
REQ-038 scan_en=1, scan_mask=4'b1010 (N_CHAN=4) -> frames on channels 1,3,1,3; ncs high >= CS_IDLE half-periods between frames.
REQ-039 start edge during SHIFT -> current frame unaffected; overrun=1 and stays 1 until nreset.
REQ-040 nreset low at sck period 7 -> ncs=1 and sck=0 asynchronously; no data_valid; next start produces a full, correct frame.
REQ-041 HALF_DIV=2 -> sck period equals 4 clk cycles; mosi stable across every sck rising edge.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and frame layout constants for the adc_scan SPI conversion controller.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD
    } state_e;

    // Frame layout: start, SGL/DIFF, channel[CH_W], MSBF, null, data[RES_BITS]
    localparam int unsigned OFS_SGL      = 1;
    localparam int unsigned OFS_CHAN     = 2;
    localparam int unsigned N_FIXED_BITS = 4;

    function automatic int unsigned frame_len(input int unsigned ch_w, input int unsigned res_bits);
        return N_FIXED_BITS + ch_w + res_bits;
    endfunction

endpackage

// File: rtl/clk_div.sv
// Half-period tick generator for sck; the count restarts whenever it is disabled.
module clk_div #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic en_i,
    output logic tick_c_o
);

    localparam int unsigned CNT_W = $clog2(HALF_DIV);

    logic [CNT_W-1:0] cnt_q;

    assign tick_c_o = en_i && (cnt_q == CNT_W'(HALF_DIV - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (!en_i || tick_c_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_scan.sv
// SPI mode-0 ADC controller: single-shot conversions plus round-robin scanning of masked channels.
module adc_scan
    import adc_pkg::*;
#(
    parameter int unsigned N_CHAN   = 2,
    parameter int unsigned RES_BITS = 10,
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned CS_IDLE  = 2,
    localparam int unsigned CH_W    = $clog2(N_CHAN)
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    input  logic [CH_W-1:0]     chan,
    input  logic                diff,
    input  logic                scan_en,
    input  logic [N_CHAN-1:0]   scan_mask,
    input  logic                miso,
    output logic                mosi,
    output logic                sck,
    output logic                ncs,
    output logic                busy,
    output logic [RES_BITS-1:0] data,
    output logic [CH_W-1:0]     data_chan,
    output logic                data_valid,
    output logic                overrun
);

    localparam int unsigned FRAME    = frame_len(CH_W, RES_BITS);
    localparam int unsigned OFS_MSBF = OFS_CHAN + CH_W;
    localparam int unsigned BIT_W    = $clog2(FRAME);
    localparam int unsigned HOLD_W   = $clog2(CS_IDLE + 1);

    state_e              state_q;
    logic                start_q;
    logic [CH_W-1:0]     chan_q;
    logic                diff_q;
    logic [CH_W-1:0]     scan_ptr_q;
    logic [BIT_W-1:0]    bit_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [RES_BITS-1:0] shreg_q;
    logic                sck_q;
    logic                ncs_q;
    logic                mosi_q;
    logic                busy_q;
    logic [RES_BITS-1:0] data_q;
    logic [CH_W-1:0]     data_chan_q;
    logic                data_valid_q;
    logic                overrun_q;

    logic                tick_c;
    logic                start_edge_c;
    logic                scan_found_c;
    logic [CH_W-1:0]     scan_next_c;
    logic                launch_c;
    logic                launch_scan_c;
    logic                rise_c;

    clk_div #(.HALF_DIV(HALF_DIV)) u_clk_div (
        .clk     (clk),
        .nreset  (nreset),
        .en_i    (state_q != ST_IDLE),
        .tick_c_o(tick_c)
    );

    // mosi level for a given frame bit; everything past the channel field is 1
    function automatic logic bit_at(input logic [BIT_W-1:0] idx, input logic d,
                                    input logic [CH_W-1:0] c);
        int unsigned     p;
        logic [CH_W-1:0] sh;
        p  = 32'(idx);
        sh = c << (p - OFS_CHAN);
        bit_at = 1'b1;
        if (p == OFS_SGL) begin
            bit_at = ~d;
        end else if (p >= OFS_CHAN && p < OFS_MSBF) begin
            bit_at = sh[CH_W-1];
        end
    endfunction

    assign start_edge_c = start && !start_q;
    assign rise_c = tick_c && ((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT && !sck_q));

    // Next masked channel strictly above the scan pointer, wrapping modulo N_CHAN
    always_comb begin
        scan_found_c = 1'b0;
        scan_next_c  = scan_ptr_q;
        for (int unsigned i = 1; i <= N_CHAN; i++) begin
            if (!scan_found_c && scan_mask[CH_W'(scan_ptr_q + CH_W'(i))]) begin
                scan_found_c = 1'b1;
                scan_next_c  = CH_W'(scan_ptr_q + CH_W'(i));
            end
        end
    end

    always_comb begin
        launch_c      = 1'b0;
        launch_scan_c = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start_edge_c) begin
                launch_c = 1'b1;
            end else if (scan_en && scan_found_c) begin
                launch_c      = 1'b1;
                launch_scan_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            chan_q       <= '0;
            diff_q       <= 1'b0;
            scan_ptr_q   <= CH_W'(N_CHAN - 1);
            bit_q        <= '0;
            hold_q       <= '0;
            shreg_q      <= '0;
            sck_q        <= 1'b0;
            ncs_q        <= 1'b1;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= '0;
            data_chan_q  <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            start_q      <= start;
            data_valid_q <= 1'b0;

            if (start_edge_c && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end

            // Every sck rise shifts miso in; the last rise of the frame completes the word
            if (rise_c) begin
                shreg_q <= {shreg_q[RES_BITS-2:0], miso};
                if (bit_q == BIT_W'(FRAME - 1)) begin
                    data_q       <= {shreg_q[RES_BITS-2:0], miso};
                    data_chan_q  <= chan_q;
                    data_valid_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (launch_c) begin
                        chan_q  <= launch_scan_c ? scan_next_c : chan;
                        diff_q  <= diff;
                        state_q <= ST_CS_SETUP;
                        ncs_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        mosi_q  <= 1'b1;
                        bit_q   <= '0;
                        if (launch_scan_c) begin
                            scan_ptr_q <= scan_next_c;
                        end
                    end
                end
                ST_CS_SETUP: begin
                    if (tick_c) begin
                        state_q <= ST_SHIFT;
                        sck_q   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tick_c) begin
                        sck_q <= ~sck_q;
                        if (sck_q) begin
                            if (bit_q == BIT_W'(FRAME - 1)) begin
                                state_q <= ST_CS_HOLD;
                                ncs_q   <= 1'b1;
                                hold_q  <= '0;
                            end else begin
                                bit_q  <= bit_q + BIT_W'(1);
                                mosi_q <= bit_at(bit_q + BIT_W'(1), diff_q, chan_q);
                            end
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (tick_c) begin
                        if (hold_q == HOLD_W'(CS_IDLE - 1)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            mosi_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mosi       = mosi_q;
    assign sck        = sck_q;
    assign ncs        = ncs_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_chan  = data_chan_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_scan.sv
// Bench for adc_scan: two instances (default, and 8-channel/12-bit/fast sck) against an ADC model.
module tb_adc_scan;

    typedef struct {
        int          periods;
        logic [31:0] bits;
    } frame_t;

    typedef struct {
        logic [11:0] data;
        int          chan;
    } dv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: N_CHAN=2, RES_BITS=10, HALF_DIV=4, CS_IDLE=2
    logic       a_nreset, a_start, a_diff, a_scan_en;
    logic [0:0] a_chan;
    logic [1:0] a_mask;
    logic       a_miso = 1'b0;
    logic       a_mosi, a_sck, a_ncs, a_busy, a_dv, a_ovr;
    logic [9:0] a_data;
    logic [0:0] a_dchan;

    // Instance B: N_CHAN=8, RES_BITS=12, HALF_DIV=2, CS_IDLE=1
    logic        b_nreset, b_start, b_diff, b_scan_en;
    logic [2:0]  b_chan;
    logic [7:0]  b_mask;
    logic        b_miso = 1'b0;
    logic        b_mosi, b_sck, b_ncs, b_busy, b_dv, b_ovr;
    logic [11:0] b_data;
    logic [2:0]  b_dchan;

    adc_scan #(.N_CHAN(2), .RES_BITS(10), .HALF_DIV(4), .CS_IDLE(2)) u_a (
        .clk(clk), .nreset(a_nreset), .start(a_start), .chan(a_chan), .diff(a_diff),
        .scan_en(a_scan_en), .scan_mask(a_mask), .miso(a_miso), .mosi(a_mosi), .sck(a_sck),
        .ncs(a_ncs), .busy(a_busy), .data(a_data), .data_chan(a_dchan), .data_valid(a_dv),
        .overrun(a_ovr)
    );

    adc_scan #(.N_CHAN(8), .RES_BITS(12), .HALF_DIV(2), .CS_IDLE(1)) u_b (
        .clk(clk), .nreset(b_nreset), .start(b_start), .chan(b_chan), .diff(b_diff),
        .scan_en(b_scan_en), .scan_mask(b_mask), .miso(b_miso), .mosi(b_mosi), .sck(b_sck),
        .ncs(b_ncs), .busy(b_busy), .data(b_data), .data_chan(b_dchan), .data_valid(b_dv),
        .overrun(b_ovr)
    );

    // ADC model state: per-channel sample values, frames seen on the wire, data_valid log
    logic [9:0]  a_adc [0:1];
    logic [11:0] b_adc [0:7];
    frame_t      a_frames[$], b_frames[$];
    dv_t         a_dvq[$], b_dvq[$];

    int          a_k = -1, b_k = -1, a_d, b_d;
    logic [31:0] a_bits = '0, b_bits = '0;
    logic [9:0]  a_v;
    logic [11:0] b_v;
    logic        a_ncs_p = 1'b1, a_sck_p = 1'b0, b_ncs_p = 1'b1, b_sck_p = 1'b0;
    logic        b_mosi_p = 1'b0;
    int          b_per_bad = 0, b_mosi_bad = 0;
    time         b_rise = 0, b_ncs_rise = 0, b_min_gap = 1000000;

    // Slave side of A: records mosi on sck rises, drives the addressed channel's value MSB first
    always @(a_ncs or a_sck) begin
        if (a_ncs === 1'b0 && a_ncs_p === 1'b1) begin
            a_k = -1; a_bits = '0; a_miso = 1'($urandom);
        end else if (a_ncs === 1'b1 && a_ncs_p === 1'b0) begin
            a_frames.push_back('{a_k + 1, a_bits});
        end else if (a_ncs === 1'b0 && a_sck !== a_sck_p) begin
            if (a_sck === 1'b1) begin
                a_k++; a_bits[31 - a_k] = a_mosi;
            end else begin
                a_d = a_k + 1 - 5;
                a_v = a_adc[a_bits[29]] << a_d;
                a_miso = (a_d >= 0 && a_d < 10) ? a_v[9] : 1'($urandom);
            end
        end
        a_ncs_p = a_ncs; a_sck_p = a_sck;
    end

    always @(b_ncs or b_sck) begin
        if (b_ncs === 1'b0 && b_ncs_p === 1'b1) begin
            b_k = -1; b_bits = '0; b_miso = 1'($urandom);
            if (b_ncs_rise > 0 && ($time - b_ncs_rise) < b_min_gap) b_min_gap = $time - b_ncs_rise;
        end else if (b_ncs === 1'b1 && b_ncs_p === 1'b0) begin
            b_frames.push_back('{b_k + 1, b_bits});
            b_ncs_rise = $time;
        end else if (b_ncs === 1'b0 && b_sck !== b_sck_p) begin
            if (b_sck === 1'b1) begin
                b_k++; b_bits[31 - b_k] = b_mosi;
                if (b_k > 0 && ($time - b_rise) != 40) b_per_bad++;
                b_rise = $time;
            end else begin
                b_d = b_k + 1 - 7;
                b_v = b_adc[b_bits[29:27]] << b_d;
                b_miso = (b_d >= 0 && b_d < 12) ? b_v[11] : 1'($urandom);
            end
        end
        b_ncs_p = b_ncs; b_sck_p = b_sck;
    end

    always @(negedge clk) if (a_dv === 1'b1) a_dvq.push_back('{12'(a_data), int'(a_dchan)});
    always @(negedge clk) if (b_dv === 1'b1) b_dvq.push_back('{b_data, int'(b_dchan)});

    always @(negedge clk) begin
        if (b_ncs === 1'b0 && b_sck === 1'b1 && b_mosi !== b_mosi_p) b_mosi_bad++;
        b_mosi_p = b_mosi;
    end

    // Expected mosi frame, first bit at [31]: 1, ~diff, channel MSB first, then 1s for MSBF/null/data
    function automatic logic [31:0] exp_bits(input int chw, input int res, input logic d, input int ch);
        logic [31:0] b;
        b = '0;
        b[31] = 1'b1;
        b[30] = ~d;
        for (int i = 0; i < chw; i++) b[29 - i] = 1'((ch >> (chw - 1 - i)) & 1);
        for (int i = 0; i < res + 2; i++) b[29 - chw - i] = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One single-shot frame on A; inputs flip right after launch, optional start poke mid-frame
    task automatic a_frame(input logic ch, input logic d, input int poke);
        int fb, db;
        fb = a_frames.size(); db = a_dvq.size();
        a_chan = ch; a_diff = d; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_chan = ~ch; a_diff = ~d;
        if (poke >= 0) begin
            for (int i = 0; i < 1000 && a_k < poke; i++) @(negedge clk);
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
        end
        for (int i = 0; i < 3000 && (a_busy || a_frames.size() == fb); i++) @(negedge clk);
        check("a_done", {a_busy, 1'(a_frames.size() > fb)}, 2'b01);
        if (a_frames.size() > fb) begin
            check("a_periods", a_frames[fb].periods, 15);
            check("a_mosi_bits", a_frames[fb].bits, exp_bits(1, 10, d, int'(ch)));
        end
        check("a_dv_count", a_dvq.size() - db, 1);
        if (a_dvq.size() > db) begin
            check("a_data", a_dvq[db].data, 12'(a_adc[ch]));
            check("a_data_chan", a_dvq[db].chan, int'(ch));
        end
    endtask

    task automatic b_frame(input logic [2:0] ch, input logic d);
        int fb, db;
        fb = b_frames.size(); db = b_dvq.size();
        b_chan = ch; b_diff = d; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_chan = ~ch; b_diff = ~d;
        for (int i = 0; i < 3000 && (b_busy || b_frames.size() == fb); i++) @(negedge clk);
        check("b_done", {b_busy, 1'(b_frames.size() > fb)}, 2'b01);
        if (b_frames.size() > fb) begin
            check("b_periods", b_frames[fb].periods, 19);
            check("b_mosi_bits", b_frames[fb].bits, exp_bits(3, 12, d, int'(ch)));
        end
        check("b_dv_count", b_dvq.size() - db, 1);
        if (b_dvq.size() > db) begin
            check("b_data", b_dvq[db].data, b_adc[ch]);
            check("b_data_chan", b_dvq[db].chan, int'(ch));
        end
    endtask

    initial begin
        int fb, db;
        logic [2:0] rc;
        logic       rd;

        a_nreset = 1'b0; a_start = 1'b0; a_chan = '0; a_diff = 1'b0; a_scan_en = 1'b0; a_mask = '0;
        b_nreset = 1'b0; b_start = 1'b0; b_chan = '0; b_diff = 1'b0; b_scan_en = 1'b0; b_mask = '0;
        for (int i = 0; i < 8; i++) b_adc[i] = 12'($urandom);
        repeat (3) @(negedge clk);

        check("a_reset_ctl", {a_sck, a_ncs, a_mosi, a_busy, a_dv, a_ovr}, 6'b010000);
        check("a_reset_data", {a_data, a_dchan}, '0);
        check("b_reset_ctl", {b_sck, b_ncs, b_mosi, b_busy, b_dv, b_ovr}, 6'b010000);
        check("b_reset_data", {b_data, b_dchan}, '0);

        a_nreset = 1'b1; b_nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Single-ended channel 1 returning 10'h2A5
        a_adc[0] = 10'($urandom); a_adc[1] = 10'h2A5;
        a_frame(1'b1, 1'b0, -1);
        check("a_ovr_clear", a_ovr, 0);

        // Start edge during SHIFT is ignored and flags overrun, which stays set
        a_adc[0] = 10'($urandom);
        a_frame(1'b0, 1'b0, 4);
        check("a_ovr_set", a_ovr, 1);
        a_adc[1] = 10'($urandom);
        a_frame(1'b1, 1'b1, -1);
        check("a_ovr_sticky", a_ovr, 1);

        // Reset at sck period 7 aborts the frame with no data_valid
        db = a_dvq.size();
        a_chan = 1'b1; a_diff = 1'b0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 1000 && a_k < 7; i++) @(negedge clk);
        check("a_reached_p7", a_k, 7);
        a_nreset = 1'b0;
        #1;
        check("a_rst_async", {a_sck, a_ncs, a_mosi, a_busy, a_ovr}, 5'b01000);
        repeat (3) @(negedge clk);
        a_nreset = 1'b1;
        repeat (3) @(negedge clk);
        check("a_rst_no_dv", a_dvq.size() - db, 0);
        a_adc[1] = 10'($urandom);
        a_frame(1'b1, 1'b0, -1);

        for (int n = 0; n < 3; n++) begin
            rc = 3'($urandom); rd = 1'($urandom);
            a_adc[rc[0]] = 10'($urandom);
            a_frame(rc[0], rd, -1);
        end

        // 8 channels, 12 bits, pseudo-differential channel 5
        b_frame(3'd5, 1'b1);
        for (int n = 0; n < 4; n++) begin
            rc = 3'($urandom); rd = 1'($urandom);
            b_adc[rc] = 12'($urandom);
            b_frame(rc, rd);
        end

        // Round-robin scan over channels 1 and 3
        fb = b_frames.size(); db = b_dvq.size();
        b_adc[1] = 12'($urandom); b_adc[3] = 12'($urandom);
        b_diff = 1'b0; b_mask = 8'b0000_1010; b_scan_en = 1'b1;
        for (int i = 0; i < 3000 && b_dvq.size() < db + 4; i++) @(negedge clk);
        b_scan_en = 1'b0;
        for (int i = 0; i < 3000 && b_busy; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("b_scan_frames", b_frames.size() - fb, 4);
        check("b_scan_dv", b_dvq.size() - db, 4);
        for (int j = 0; j < 4 && db + j < b_dvq.size() && fb + j < b_frames.size(); j++) begin
            check("b_scan_chan", b_dvq[db + j].chan, (j % 2 == 1) ? 3 : 1);
            check("b_scan_data", b_dvq[db + j].data, b_adc[(j % 2 == 1) ? 3 : 1]);
            check("b_scan_bits", b_frames[fb + j].bits, exp_bits(3, 12, 1'b0, (j % 2 == 1) ? 3 : 1));
        end
        check("b_scan_gap", 1'(b_min_gap >= 20), 1);
        check("b_sck_period", b_per_bad, 0);
        check("b_mosi_stable", b_mosi_bad, 0);
        check("b_ovr_clear", b_ovr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
